instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/pc_reg.sv | 22 ++
 rtl/instruction_fetch.sv | 90 +++++++++
 tb/tb_instruction_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, widths, the default
// halt opcode and the fetch-unit state encoding, plus field-extract helpers.
package cpu_pkg;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    // Instruction word layout: [15:12] opcode, [11:10] reg1, [9:8] reg2,
    // [7:0] RAM address / jump target.
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int R1_MSB  = 11;
    localparam int R1_LSB  = 10;
    localparam int R2_MSB  = 9;
    localparam int R2_LSB  = 8;
    localparam int ADR_MSB = 7;
    localparam int ADR_LSB = 0;

    localparam logic [3:0] HALT_OP_DEFAULT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_HALT
    } fetch_state_t;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] target_of(input logic [INSTR_W-1:0] w);
        return w[ADR_MSB:ADR_LSB];
    endfunction
endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset to RESET_PC, load (jump) has priority
// over increment; increment wraps 8'hFF -> 8'h00.
// Ports: clk, rst, load, inc, load_val[7:0] in; pc[7:0] out.
module pc_reg import cpu_pkg::*; #(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + 1'b1;  // natural 8-bit wrap
    end
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit. Reads one 16-bit word per instruction from a
// program memory with 1-cycle read latency, holds it for the control unit
// until accepted, then advances or jumps the PC. A HALT_OP instruction,
// once accepted, parks the unit until reset.
// Ports: clk, rst, start in; imem_rd_en, imem_addr[7:0] out,
//        imem_rdata[15:0] in; instruction[15:0], instr_valid out;
//        instr_ready, pc_jump in; pc[7:0], halted, retired[15:0] out.
module instruction_fetch import cpu_pkg::*; #(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter logic [3:0]        HALT_OP  = HALT_OP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               pc_jump,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic [15:0]        retired
);
    fetch_state_t state, state_nxt;
    logic handshake, is_halt, pc_load, pc_inc;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        imem_rd_en  = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FETCH;
            ST_FETCH: begin
                imem_rd_en = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT:  state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready)
                    state_nxt = is_halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT:  halted = 1'b1;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign is_halt   = (opcode_of(instruction) == HALT_OP);
    assign handshake = instr_valid & instr_ready;
    // A halting instruction leaves pc pointing at itself; pc_jump is don't-care.
    assign pc_load   = handshake & ~is_halt & pc_jump;
    assign pc_inc    = handshake & ~is_halt & ~pc_jump;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .inc      (pc_inc),
        .load_val (target_of(instruction)),
        .pc       (pc)
    );

    assign imem_addr = pc;

    // Read data arrives during WAIT; capture it at the end of that cycle.
    // Reset wins, so a read in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (rst)
            instruction <= '0;
        else if (state == ST_WAIT)
            instruction <= imem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            retired <= '0;
        else if (handshake && retired != 16'hFFFF)
            retired <= retired + 1'b1;
    end
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst, start, instr_ready, pc_jump;
    logic        imem_rd_en, instr_valid, halted;
    logic [7:0]  imem_addr, pc;
    logic [15:0] imem_rdata = 16'h0, instruction, retired;
    // second instance with RESET_PC = 8'hFF
    logic        rd_en2, valid2, halted2;
    logic [7:0]  addr2, pc2;
    logic [15:0] rdata2 = 16'h0, instr2, retired2;

    logic [15:0] mem [256];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .start(start), .imem_rd_en(imem_rd_en),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instruction(instruction),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_jump(pc_jump),
        .pc(pc), .halted(halted), .retired(retired)
    );

    instruction_fetch #(.RESET_PC(8'hFF)) dut_ff (
        .clk(clk), .rst(rst), .start(start), .imem_rd_en(rd_en2),
        .imem_addr(addr2), .imem_rdata(rdata2), .instruction(instr2),
        .instr_valid(valid2), .instr_ready(instr_ready), .pc_jump(pc_jump),
        .pc(pc2), .halted(halted2), .retired(retired2)
    );

    // program memories with one cycle of read latency
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
        if (rd_en2)     rdata2     <= mem[addr2];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; instr_ready = 1'b0; pc_jump = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] word;
        logic        jump;
        int          stall;
        logic [7:0]  exp_next;
        logic [15:0] exp_ret;
    } vec_t;

    vec_t vecs [6];

    // reference model state for the random phase
    bit          running, halted_m, fetch_due;
    int          since;
    logic [7:0]  pc_m;
    logic [15:0] ret_m;

    initial begin
        vecs[0] = '{8'h00, 16'h4D00, 1'b0, 0, 8'h01, 16'd1};
        vecs[1] = '{8'h01, 16'h2005, 1'b1, 5, 8'h05, 16'd2};
        vecs[2] = '{8'h05, 16'h3080, 1'b0, 2, 8'h06, 16'd3};
        vecs[3] = '{8'h06, 16'h50FE, 1'b1, 0, 8'hFE, 16'd4};
        vecs[4] = '{8'hFE, 16'h6000, 1'b0, 1, 8'hFF, 16'd5};
        vecs[5] = '{8'hFF, 16'h7011, 1'b0, 0, 8'h00, 16'd6};
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        foreach (vecs[i]) mem[vecs[i].addr] = vecs[i].word;

        // ---- reset state ----
        do_reset();
        chk("rst_rd_en", imem_rd_en, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_pc", pc, 8'h00);
        chk("rst_halted", halted, 0);
        chk("rst_retired", retired, 0);
        chk("rst_pc_ff", pc2, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_no_fetch", imem_rd_en, 0);
        end

        // ---- table-driven instruction sequence ----
        pulse_start();
        foreach (vecs[i]) begin
            chk("vec_fetch", imem_rd_en, 1);
            chk("vec_addr", imem_addr, vecs[i].addr);
            // ready/jump noise outside ISSUE must be ignored
            instr_ready = 1'b1; pc_jump = ~vecs[i].jump;
            tick();
            chk("vec_wait_valid", instr_valid, 0);
            tick();
            chk("vec_valid", instr_valid, 1);
            chk("vec_instr", instruction, vecs[i].word);
            for (int w = 0; w < vecs[i].stall; w++) begin
                instr_ready = 1'b0; pc_jump = ~vecs[i].jump;
                tick();
                chk("stall_valid", instr_valid, 1);
                chk("stall_instr", instruction, vecs[i].word);
                chk("stall_pc", pc, vecs[i].addr);
                chk("stall_rd_en", imem_rd_en, 0);
            end
            instr_ready = 1'b1; pc_jump = vecs[i].jump;
            tick();
            instr_ready = 1'b0;
            chk("vec_next_pc", pc, vecs[i].exp_next);
            chk("vec_retired", retired, vecs[i].exp_ret);
        end
        chk("vec_wrap_fetch", imem_rd_en, 1);
        chk("vec_wrap_addr", imem_addr, 8'h00);

        // ---- RESET_PC = 8'hFF wraps to 8'h00 ----
        mem[8'hFF] = 16'h1000;
        do_reset();
        pulse_start();
        chk("ff_fetch", rd_en2, 1);
        chk("ff_addr", addr2, 8'hFF);
        instr_ready = 1'b1; pc_jump = 1'b0;
        tick(); tick();
        chk("ff_valid", valid2, 1);
        chk("ff_instr", instr2, 16'h1000);
        tick();
        chk("ff_next_fetch", rd_en2, 1);
        chk("ff_next_addr", addr2, 8'h00);
        chk("ff_retired", retired2, 1);

        // ---- halt: jump flag must not move pc, start must not restart ----
        mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'hF000;
        do_reset();
        pulse_start();
        instr_ready = 1'b1; pc_jump = 1'b1;
        begin
            int n = 0;
            while (!halted && n < 30) begin tick(); n++; end
        end
        chk("halt_reached", halted, 1);
        chk("halt_retired", retired, 3);
        chk("halt_pc", pc, 8'h02);
        for (int c = 0; c < 20; c++) begin
            start = (c % 3 == 0);
            tick();
            chk("halt_rd_en", imem_rd_en, 0);
            chk("halt_valid", instr_valid, 0);
            chk("halt_stays", halted, 1);
        end
        start = 1'b0; instr_ready = 1'b0; pc_jump = 1'b0;

        // ---- reset during WAIT drops the in-flight read ----
        mem[0] = 16'hABCD;
        do_reset();
        pulse_start();
        chk("rw_fetch", imem_rd_en, 1);
        tick();
        rst = 1'b1; start = 1'b1; instr_ready = 1'b1; pc_jump = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; instr_ready = 1'b0; pc_jump = 1'b0;
        chk("rw_valid", instr_valid, 0);
        chk("rw_instr", instruction, 16'h0000);
        chk("rw_pc", pc, 8'h00);
        chk("rw_rd_en", imem_rd_en, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rw_idle", imem_rd_en | instr_valid, 0);
        end

        // ---- randomized run against the reference model ----
        for (int i = 0; i < 256; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'hE;
            mem[i] = w;
        end
        do_reset();
        running = 0; halted_m = 0; fetch_due = 0; since = 0;
        pc_m = 8'h00; ret_m = 16'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit exp_rd, exp_valid;
            exp_rd    = running && !halted_m && fetch_due;
            exp_valid = running && !halted_m && !fetch_due && since >= 2;
            chk("rnd_rd_en", imem_rd_en, exp_rd);
            chk("rnd_valid", instr_valid, exp_valid);
            if (exp_rd) chk("rnd_addr", imem_addr, pc_m);
            if (exp_valid) chk("rnd_instr", instruction, mem[pc_m]);
            chk("rnd_pc", pc, pc_m);
            chk("rnd_retired", retired, ret_m);
            chk("rnd_halted", halted, halted_m);

            start       = (cyc == 4) || ($urandom_range(0, 49) == 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            pc_jump     = $urandom_range(0, 1);

            // what the coming clock edge should do
            if (!running) begin
                if (start) begin running = 1; fetch_due = 1; end
            end else if (!halted_m) begin
                if (fetch_due) begin
                    fetch_due = 0; since = 1;
                end else if (since < 2) begin
                    since++;
                end else if (instr_ready) begin
                    if (ret_m != 16'hFFFF) ret_m++;
                    if (mem[pc_m][15:12] == 4'hF) halted_m = 1;
                    else pc_m = pc_jump ? mem[pc_m][7:0] : pc_m + 8'd1;
                    fetch_due = 1;
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
